// File: rtl/div_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_mon_pkg
// Description : Shared state encoding and default constants for the
//               divided-clock monitor family.
// Revision    : 1.0
// ============================================================================
package div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_ERR_W      = 8;
    localparam int DEF_EXP_PERIOD = 6;
    localparam int DEF_EXP_HIGH   = 3;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_TIMEOUT    = 64;

endpackage
`default_nettype wire

// File: rtl/div_clk_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : div_clk_monitor_if
// Description : Divided clock input plus measurement/status results.
// Revision    : 1.0
// ============================================================================
interface div_clk_monitor_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
);
    logic             div_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             err;
    logic             timeout;
    logic [ERR_W-1:0] err_count;

    // master: the monitor itself; slave: whoever drives div_in and consumes status
    modport master (
        input  div_in,
        output period, high_time, meas_valid, locked, err, timeout, err_count
    );
    modport slave (
        output div_in,
        input  period, high_time, meas_valid, locked, err, timeout, err_count
    );
endinterface
`default_nettype wire

// File: rtl/div_mon_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : div_mon_edge_det
// Description : Rising-edge detector with optional 2-flop synchronizer
//               (enabled by DIV_MON_SYNC_EN).
// Revision    : 1.0
// ============================================================================
module div_mon_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic div_in,
    output logic div_lvl,
    output logic rise
);

`ifdef DIV_MON_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = div_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign div_lvl = sync2_q;
`else
    assign div_lvl = div_in;
`endif

    logic div_q, div_d;

    always_comb div_d = div_lvl;

    always_ff @(posedge clk) begin
        if (!reset) div_q <= 1'b0;
        else        div_q <= div_d;
    end

    assign rise = div_lvl & ~div_q;

endmodule
`default_nettype wire

// File: rtl/div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module      : div_clk_monitor
// Description : Measures period/high time of a divided clock, reports lock,
//               mismatch and stuck conditions. DIV_MON_SYNC_EN adds an input
//               synchronizer (+2 cycles latency).
// Revision    : 1.0
// ============================================================================
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int EXP_HIGH   = DEF_EXP_HIGH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int ERR_W      = DEF_ERR_W
) (
    input  logic           clk,
    input  logic           reset,
    div_clk_monitor_if.master bus
);

    localparam int ICNT_W = $clog2(TIMEOUT + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    logic div_lvl;
    logic rise;

    div_mon_edge_det u_edge_det (
        .clk     (clk),
        .reset   (reset),
        .div_in  (bus.div_in),
        .div_lvl (div_lvl),
        .rise    (rise)
    );

    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [CNT_W-1:0]    hcnt_q,       hcnt_d;
    logic [ICNT_W-1:0]   icnt_q,       icnt_d;
    logic [GOOD_W-1:0]   good_cnt_q,   good_cnt_d;
    logic [CNT_W-1:0]    period_q,     period_d;
    logic [CNT_W-1:0]    high_time_q,  high_time_d;
    logic                meas_valid_q, meas_valid_d;
    logic                locked_q,     locked_d;
    logic                err_q,        err_d;
    logic                timeout_q,    timeout_d;
    logic [ERR_W-1:0]    err_count_q,  err_count_d;
    logic                meas_good;

    // Free-running measurement counters, all saturating
    always_comb begin
        cnt_d  = cnt_q;
        hcnt_d = hcnt_q;
        icnt_d = icnt_q;
        if (rise) begin
            cnt_d  = CNT_W'(1);
            hcnt_d = CNT_W'(1);
            icnt_d = '0;
        end else begin
            if (cnt_q != '1)             cnt_d  = cnt_q + 1'b1;
            if (div_lvl && hcnt_q != '1) hcnt_d = hcnt_q + 1'b1;
            if (icnt_q != '1)            icnt_d = icnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        err_d        = 1'b0;
        timeout_d    = 1'b0;
        err_count_d  = err_count_q;
        meas_good    = (cnt_q == CNT_W'(EXP_PERIOD)) && (hcnt_q == CNT_W'(EXP_HIGH));

        case (state_q)
            IDLE: begin
                if (rise) state_d = MEASURE;
            end
            MEASURE, LOCKED: begin
                // A rise coinciding with the timeout threshold is a normal measurement
                if (rise) begin
                    period_d     = cnt_q;
                    high_time_d  = hcnt_q;
                    meas_valid_d = 1'b1;
                    if (meas_good) begin
                        if (state_q == MEASURE) begin
                            good_cnt_d = good_cnt_q + 1'b1;
                            if (good_cnt_d == GOOD_W'(LOCK_COUNT)) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                            end
                        end
                    end else begin
                        err_d      = 1'b1;
                        good_cnt_d = '0;
                        locked_d   = 1'b0;
                        state_d    = MEASURE;
                    end
                end else if (icnt_q == ICNT_W'(TIMEOUT - 1)) begin
                    timeout_d  = 1'b1;
                    err_d      = 1'b1;
                    good_cnt_d = '0;
                    locked_d   = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_d && err_count_q != '1) err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            icnt_q       <= '0;
            good_cnt_q   <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            icnt_q       <= icnt_d;
            good_cnt_q   <= good_cnt_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_time_q;
    assign bus.meas_valid = meas_valid_q;
    assign bus.locked     = locked_q;
    assign bus.err        = err_q;
    assign bus.timeout    = timeout_q;
    assign bus.err_count  = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_div_clk_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_clk_monitor
// Description : Self-checking bench for div_clk_monitor against a
//               behavioural edge-timestamp model.
// Revision    : 1.0
// ============================================================================
module tb_div_clk_monitor;

    localparam int CW         = 8;
    localparam int EW         = 8;
    localparam int EXP_PERIOD = 6;
    localparam int EXP_HIGH   = 3;
    localparam int LOCK_COUNT = 4;
    localparam int TIMEOUT    = 64;
    localparam int SAT_C      = (1 << CW) - 1;
    localparam int SAT_E      = (1 << EW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    div_clk_monitor_if #(.CNT_W(CW), .ERR_W(EW)) bus ();

    div_clk_monitor #(
        .CNT_W(CW), .EXP_PERIOD(EXP_PERIOD), .EXP_HIGH(EXP_HIGH),
        .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT), .ERR_W(EW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: timestamps of rising edges and a count of high cycles since the last one
    int  n = 0;
    bit  primed, m_locked, prev_lvl, d1, d2, lvl, rise;
    int  streak, last_rise, highs, p, h;
    int  e_period, e_high, e_errc;
    bit  e_mv, e_err, e_to;

    always @(posedge clk) begin
        if (!reset) begin
            primed = 0; m_locked = 0; prev_lvl = 0; d1 = 0; d2 = 0;
            streak = 0; last_rise = 0; highs = 0;
            e_period = 0; e_high = 0; e_errc = 0; e_mv = 0; e_err = 0; e_to = 0;
        end else begin
`ifdef DIV_MON_SYNC_EN
            lvl = d2; d2 = d1; d1 = bus.div_in;
`else
            lvl = bus.div_in;
`endif
            rise = lvl && !prev_lvl;
            e_mv = 0; e_err = 0; e_to = 0;
            if (rise) begin
                if (primed) begin
                    p = n - last_rise;  if (p > SAT_C) p = SAT_C;
                    h = highs;          if (h > SAT_C) h = SAT_C;
                    e_period = p; e_high = h; e_mv = 1;
                    if (p == EXP_PERIOD && h == EXP_HIGH) begin
                        streak++;
                        if (streak >= LOCK_COUNT) m_locked = 1;
                    end else begin
                        e_err = 1; streak = 0; m_locked = 0;
                    end
                end
                primed = 1; last_rise = n; highs = 1;
            end else begin
                if (lvl) highs++;
                if (primed && (n - last_rise) == TIMEOUT) begin
                    e_to = 1; e_err = 1; primed = 0; m_locked = 0; streak = 0;
                end
            end
            if (e_err && e_errc < SAT_E) e_errc++;
            prev_lvl = lvl;
        end
        n++;
        #1;
        chk("period",     bus.period,     e_period);
        chk("high_time",  bus.high_time,  e_high);
        chk("meas_valid", bus.meas_valid, e_mv);
        chk("locked",     bus.locked,     m_locked);
        chk("err",        bus.err,        e_err);
        chk("timeout",    bus.timeout,    e_to);
        chk("err_count",  bus.err_count,  e_errc);
    end

    task automatic cyc(input bit v);
        @(negedge clk);
        bus.div_in = v;
    endtask

    task automatic wave(input int hi, input int lo, input int count);
        for (int k = 0; k < count; k++) begin
            repeat (hi) cyc(1'b1);
            repeat (lo) cyc(1'b0);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic lit_all_zero(input string tag);
        chk({tag, "_period"},    bus.period,     0);
        chk({tag, "_high"},      bus.high_time,  0);
        chk({tag, "_mv"},        bus.meas_valid, 0);
        chk({tag, "_locked"},    bus.locked,     0);
        chk({tag, "_err"},       bus.err,        0);
        chk({tag, "_timeout"},   bus.timeout,    0);
        chk({tag, "_err_count"}, bus.err_count,  0);
    endtask

    initial begin
        int sel;
        bus.div_in = 1'b0;
        repeat (3) @(negedge clk);
        lit_all_zero("lit_reset");
        reset = 1'b1;

        // Ideal 3/3: priming rise + 4 good measurements
        wave(3, 3, 5);
        chk("lit_lock_locked", bus.locked, 1);
        chk("lit_lock_period", bus.period, 6);
        chk("lit_lock_high",   bus.high_time, 3);
        chk("lit_lock_errc",   bus.err_count, 0);

        // One stretched low phase
        wave(3, 4, 1);
        wave(3, 3, 1);
        chk("lit_stretch_period", bus.period, 7);
        chk("lit_stretch_locked", bus.locked, 0);
        chk("lit_stretch_errc",   bus.err_count, 1);
        wave(3, 3, 4);
        chk("lit_relock_locked", bus.locked, 1);
        chk("lit_relock_errc",   bus.err_count, 1);

        // Stuck low while locked
        repeat (70) cyc(1'b0);
        chk("lit_to_locked", bus.locked, 0);
        chk("lit_to_errc",   bus.err_count, 2);
        wave(3, 3, 5);
        chk("lit_to_relock", bus.locked, 1);

        // Duty 2/4: first rise closes a good 3/3 period, then 5 bad ones
        wave(2, 4, 6);
        chk("lit_duty_locked", bus.locked, 0);
        chk("lit_duty_errc",   bus.err_count, 7);

        // Reset pulse mid-measure
        wave(3, 3, 2);
        reset_pulse();
        lit_all_zero("lit_midreset");

        // Saturation: priming rise then 301 bad periods
        wave(2, 4, 302);
        chk("lit_sat_errc", bus.err_count, 255);

        // Randomized traffic
        reset_pulse();
        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      wave(3, 3, 1);
            else if (sel == 6) wave($urandom_range(1, 6), $urandom_range(1, 6), 1);
            else if (sel == 7) repeat ($urandom_range(40, 80)) cyc(1'($urandom_range(0, 1)));
            else if (sel == 8) repeat (10) cyc(1'($urandom_range(0, 1)));
            else               reset_pulse();
        end
        repeat (4) cyc(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
Downstream consumer of the divide-by-6 clock output. Samples the divided signal in the fast `clk` domain and measures each period and each high time in `clk` cycles. Compares every measurement against expected values and reports lock, mismatch and stuck conditions. Used in-system to qualify the divider before logic starts relying on its output.

Parameters:
CNT_W, 8, width of the period/high-time counters and outputs
EXP_PERIOD, 6, expected period in clk cycles
EXP_HIGH, 3, expected high time in clk cycles
LOCK_COUNT, 4, consecutive good periods required to assert locked
TIMEOUT, 64, clk cycles without a rising edge before a stuck error
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock; the same clock that drives the divider
reset  input  1  synchronous, active-low reset
div_in  input  1  divided clock under test, generated in the clk domain
period  output  CNT_W  last measured period, rising edge to rising edge
high_time  output  CNT_W  last measured high time
meas_valid  output  1  one-cycle pulse when period/high_time update
locked  output  1  LOCK_COUNT consecutive good periods seen
err  output  1  one-cycle pulse on a mismatch or timeout
timeout  output  1  one-cycle pulse when no rising edge arrives within TIMEOUT
err_count  output  ERR_W  saturating count of err pulses

Behaviour:
- All state updates on posedge clk. reset low on a clock edge clears everything: state=IDLE, all outputs 0, div_q=0, counters 0.
- Edge detect: div_q registers div_in. rise = div_in & ~div_q, evaluated combinationally in the current cycle.
- Period counter cnt:
  - Set to 1 on a rise cycle; otherwise increments.
  - Saturates at all-ones.
- High counter hcnt:
  - Set to 1 on a rise cycle.
  - Otherwise increments while div_in=1 and holds while div_in=0.
  - Saturates at all-ones.
- Idle counter icnt: cleared on rise, otherwise increments, saturating.
- States:
  - IDLE: wait for the first rise, then go to MEASURE. No measurement is produced on this first rise.
  - MEASURE: on each rise, latch period<=cnt and high_time<=hcnt, and pulse meas_valid in the next cycle. The measurement is good iff cnt==EXP_PERIOD && hcnt==EXP_HIGH.
    - Good: increment good_cnt. When good_cnt reaches LOCK_COUNT, go to LOCKED and set locked=1.
    - Bad: pulse err, clear good_cnt, stay in MEASURE.
  - LOCKED: each rise still updates period/high_time/meas_valid.
    - A bad measurement pulses err, clears locked and good_cnt, and returns to MEASURE.
- Latency: period, high_time, meas_valid and err are all registered and appear 1 cycle after the rise cycle.
- Timeout: in MEASURE or LOCKED, when icnt reaches TIMEOUT-1 with no rise:
  - pulse timeout and err;
  - clear locked and good_cnt;
  - go to IDLE.
  - IDLE never times out.
- Rise in the same cycle as timeout: the rise wins and is treated as a normal measurement.
- err_count increments on every err pulse and saturates at all-ones.
- A reset during any state aborts it immediately. No partial measurement is reported after reset.

Optional Feature:
DIV_MON_SYNC_EN:
- Defined: div_in passes through a 2-flop synchronizer before edge detection, allowing an asynchronous source. All output latencies grow by 2 cycles. The synchronizer flops reset to 0.
- Undefined: div_in is used directly, as it is the same-domain divider output.

Decomposition:
- Package div_mon_pkg holds:
  - the state enum (IDLE, MEASURE, LOCKED);
  - the default constants EXP_PERIOD, EXP_HIGH, LOCK_COUNT, TIMEOUT.
- One natural sub-module: div_mon_edge_det. It contains the optional synchronizer, div_q and the rise output, and is reusable by other monitors.

Test Plan:
- Ideal pattern, 3 high/3 low repeating, after reset release: the first rise gives no output. Then meas_valid every 6 cycles with period=6 and high_time=3. locked=1 after the 4th good measurement; err_count stays 0.
- While locked, stretch one low phase to 4 cycles (period 7): one err pulse, period=7, locked falls, err_count=1. locked re-asserts after 4 further good periods.
- Duty 2/4 (period 6, high 2): err on every measurement, locked never asserts, err_count increments each period.
- Hold div_in=0 for 64 cycles while locked: timeout and err pulse exactly once, state IDLE, locked=0. Resuming the pattern needs 1 priming rise plus 4 good periods to re-lock.
- Reset pulled low mid-MEASURE for 1 cycle (testbench-style short reset pulse): all outputs 0 on the next cycle, and the next rise is treated as the priming rise.
- Force 300 error events: err_count saturates at 255 and does not wrap.
